// File: rtl/logs_pkg.sv
// ----------------------------------------------------------------------------
// logs_pkg
//   Constants shared by the logistic sound path: the PWM demodulator window
//   length and the clog2-derived count width. The mixer's count width uses
//   the same helper, so both ends of the link agree on the sample width.
// ----------------------------------------------------------------------------
package logs_pkg;

    // Default demodulator window, in clk cycles per output sample.
    localparam int LOGS_DEMOD_WINDOW = 64;

    // Width needed to hold a count from 0 up to and including n.
    function automatic int logs_count_bits(input int n);
        return $clog2(n + 1);
    endfunction

    // Sample/edge width for the default window (7 bits for 64 cycles).
    localparam int LOGS_DEMOD_SAMPLE_BITS = logs_count_bits(LOGS_DEMOD_WINDOW);

    // Default synchroniser depth on asynchronous single-bit inputs.
    localparam int LOGS_SYNC_STAGES = 2;

endpackage

// File: rtl/logs_sync.sv
// ----------------------------------------------------------------------------
// logs_sync
//   N-stage flip-flop synchroniser for a single asynchronous bit.
//   Every stage clears on reset, so the output is 0 until a real input
//   value has travelled through the whole chain.
// Ports
//   i_clk  destination clock
//   i_rst  asynchronous reset, active high
//   i_d    asynchronous input bit
//   o_q    synchronised bit, STAGES cycles behind i_d
// ----------------------------------------------------------------------------
module logs_sync
    import logs_pkg::*;
#(
    parameter int STAGES = LOGS_SYNC_STAGES
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_chain;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/logs_pwm_demod.sv
// ----------------------------------------------------------------------------
// logs_pwm_demod
//   Receive end of the 1-bit PWM audio link. The bitstream is synchronised,
//   then boxcar-integrated over back-to-back windows of WINDOW cycles. Each
//   window yields a duty sample (high cycles) and a rising-edge count; both
//   are presented through a 1-deep valid/ready buffer.
// Ports
//   i_clk            system clock
//   i_reset          asynchronous reset, active high
//   i_snd_in         PWM bitstream, may be asynchronous to i_clk
//   o_sample         high cycles in the last loaded window
//   o_edges          0->1 transitions in the last loaded window
//   o_sample_valid   o_sample/o_edges hold an unconsumed result
//   i_sample_ready   consumer takes the result when valid & ready at posedge
//   o_overflow       sticky: a window result was dropped
//   i_overflow_clr   synchronous clear of o_overflow
// ----------------------------------------------------------------------------
module logs_pwm_demod
    import logs_pkg::*;
#(
    parameter int WINDOW      = LOGS_DEMOD_WINDOW,
    parameter int SAMPLE_BITS = LOGS_DEMOD_SAMPLE_BITS,
    parameter int SYNC_STAGES = LOGS_SYNC_STAGES
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_snd_in,
    output logic [SAMPLE_BITS-1:0] o_sample,
    output logic [SAMPLE_BITS-1:0] o_edges,
    output logic                   o_sample_valid,
    input  logic                   i_sample_ready,
    output logic                   o_overflow,
    input  logic                   i_overflow_clr
);

    localparam int CNT_W = (WINDOW > 2) ? $clog2(WINDOW) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WINDOW - 1);

    // ------------------------------------------------------------------
    // Input synchroniser and edge detector
    // ------------------------------------------------------------------
    logic w_snd_s;
    logic r_prev;
    logic w_rise;

    logs_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .i_clk (i_clk),
        .i_rst (i_reset),
        .i_d   (i_snd_in),
        .o_q   (w_snd_s)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= w_snd_s;
        end
    end

    assign w_rise = w_snd_s & ~r_prev;

    // ------------------------------------------------------------------
    // Window counter
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] r_cnt;
    logic             w_win_end;

    assign w_win_end = (r_cnt == CNT_LAST);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_cnt <= '0;
        end else if (w_win_end) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Accumulators. The *_next values include the current cycle, so at
    // the window end they are the complete window result; the registers
    // then restart from zero with no dead cycle between windows.
    // acc never exceeds WINDOW, which SAMPLE_BITS holds by construction.
    // ------------------------------------------------------------------
    logic [SAMPLE_BITS-1:0] r_acc;
    logic [SAMPLE_BITS-1:0] r_ecnt;
    logic [SAMPLE_BITS-1:0] w_acc_next;
    logic [SAMPLE_BITS-1:0] w_ecnt_next;

    assign w_acc_next  = r_acc  + SAMPLE_BITS'(w_snd_s);
    assign w_ecnt_next = r_ecnt + SAMPLE_BITS'(w_rise);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_acc  <= '0;
            r_ecnt <= '0;
        end else if (w_win_end) begin
            r_acc  <= '0;
            r_ecnt <= '0;
        end else begin
            r_acc  <= w_acc_next;
            r_ecnt <= w_ecnt_next;
        end
    end

    // ------------------------------------------------------------------
    // Output buffer. A window result loads if the slot is empty or is
    // being consumed this same edge; otherwise it is dropped and the
    // held result stays untouched.
    // ------------------------------------------------------------------
    logic                   r_valid;
    logic [SAMPLE_BITS-1:0] r_sample;
    logic [SAMPLE_BITS-1:0] r_edges;
    logic                   r_overflow;
    logic                   w_take;
    logic                   w_load;
    logic                   w_drop;

    assign w_take = r_valid & i_sample_ready;
    assign w_load = w_win_end & (~r_valid | i_sample_ready);
    assign w_drop = w_win_end & r_valid & ~i_sample_ready;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_valid  <= 1'b0;
            r_sample <= '0;
            r_edges  <= '0;
        end else if (w_load) begin
            r_valid  <= 1'b1;
            r_sample <= w_acc_next;
            r_edges  <= w_ecnt_next;
        end else if (w_take) begin
            // Data is left stale; only the valid bit drops.
            r_valid  <= 1'b0;
        end
    end

    // A drop in the same cycle as a clear keeps the flag set, so no
    // dropped result can go unreported.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (i_overflow_clr) begin
            r_overflow <= 1'b0;
        end
    end

    assign o_sample       = r_sample;
    assign o_edges        = r_edges;
    assign o_sample_valid = r_valid;
    assign o_overflow     = r_overflow;

endmodule

// File: tb/tb_logs_pwm_demod.sv
// ----------------------------------------------------------------------------
// tb_logs_pwm_demod
//   Directed bench for logs_pwm_demod (WINDOW=64, SYNC_STAGES=2). Cycle
//   numbers in comments count clk edges since the latest reset release.
// ----------------------------------------------------------------------------
module tb_logs_pwm_demod;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       snd_in = 1'b0;
    logic       sample_ready = 1'b0;
    logic       overflow_clr = 1'b0;
    logic [6:0] sample;
    logic [6:0] edges;
    logic       sample_valid;
    logic       overflow;

    int total = 0;
    int bad   = 0;

    logic       sq_en = 1'b0;
    logic [1:0] sq_ph = 2'd0;

    always #5 clk = ~clk;

    logs_pwm_demod #(
        .WINDOW      (64),
        .SAMPLE_BITS (7),
        .SYNC_STAGES (2)
    ) dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_snd_in       (snd_in),
        .o_sample       (sample),
        .o_edges        (edges),
        .o_sample_valid (sample_valid),
        .i_sample_ready (sample_ready),
        .o_overflow     (overflow),
        .i_overflow_clr (overflow_clr)
    );

    // Advance n clk edges, ending 1 time unit after the last one. When the
    // square generator is on, snd_in toggles every 2 edges (period 4).
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (sq_en) begin
                snd_in = sq_ph[1];
                sq_ph  = sq_ph + 2'd1;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input int v, input int s, input int e, input int o);
        chk({tag, ".valid"},    32'(sample_valid), 32'(v));
        chk({tag, ".sample"},   32'(sample),       32'(s));
        chk({tag, ".edges"},    32'(edges),        32'(e));
        chk({tag, ".overflow"}, 32'(overflow),     32'(o));
    endtask

    initial begin
        // Reset state, before and after clock edges under reset
        #1;
        chk_out("rst_t0", 0, 0, 0, 0);
        step(2);
        chk_out("rst_held", 0, 0, 0, 0);

        // 1: snd_in high from reset, ready high
        snd_in       = 1'b1;
        sample_ready = 1'b1;
        reset        = 1'b0;
        step(63);                               // 63
        chk("t1_not_yet_valid", 32'(sample_valid), 32'd0);
        step(1);                                // 64: 2 sync cycles missing
        chk_out("t1_first", 1, 62, 1, 0);
        step(1);                                // 65: consumed, data stale
        chk_out("t1_consumed", 0, 62, 1, 0);
        step(63);                               // 128
        chk_out("t1_second", 1, 64, 0, 0);
        step(64);                               // 192
        chk_out("t1_third", 1, 64, 0, 0);

        // 2: snd_in low; 2 trailing high cycles still in the sync chain
        snd_in = 1'b0;
        step(64);                               // 256
        chk_out("t2_tail", 1, 2, 0, 0);
        step(64);                               // 320
        chk_out("t2_zero", 1, 0, 0, 0);
        step(1);                                // 321
        chk("t2_valid_pulse", 32'(sample_valid), 32'd0);
        step(63);                               // 384
        chk_out("t2_zero2", 1, 0, 0, 0);

        // 3: square wave, period 4, 50% duty; window 448 is transitional
        sq_en = 1'b1;
        step(128);                              // 512
        chk_out("t3_sq_a", 1, 32, 16, 0);
        step(64);                               // 576
        chk_out("t3_sq_b", 1, 32, 16, 0);
        sq_en  = 1'b0;
        snd_in = 1'b1;
        step(1);                                // 577
        chk("t3_consumed", 32'(sample_valid), 32'd0);
        step(64);                               // 641: window 640 loaded and taken
        sample_ready = 1'b0;

        // 4: ready low across 3 window ends
        step(63);                               // 704: full-high window loads
        chk_out("t4_load", 1, 64, 0, 0);
        snd_in = 1'b0;
        step(63);                               // 767
        chk_out("t4_before_drop", 1, 64, 0, 0);
        step(1);                                // 768: result 2 dropped
        chk_out("t4_drop1", 1, 64, 0, 1);
        overflow_clr = 1'b1;
        step(1);                                // 769
        chk("t4_clr", 32'(overflow), 32'd0);
        overflow_clr = 1'b0;
        step(62);                               // 831
        overflow_clr = 1'b1;
        step(1);                                // 832: drop beats clear
        chk_out("t4_drop2_vs_clr", 1, 64, 0, 1);
        step(1);                                // 833
        chk("t4_clr2", 32'(overflow), 32'd0);
        overflow_clr = 1'b0;
        snd_in       = 1'b1;

        // 5: ready raised only in the window-end cycle
        step(62);                               // 895
        sample_ready = 1'b1;
        step(1);                                // 896: edges 836..896 high
        chk_out("t5_swap", 1, 61, 1, 0);
        sample_ready = 1'b0;
        step(1);                                // 897
        chk_out("t5_hold", 1, 61, 1, 0);

        // 6: async reset mid-window (cnt = 30), ready low
        step(29);                               // 926: cnt now 30
        reset = 1'b1;
        #1;
        chk_out("t6_async", 0, 0, 0, 0);
        step(2);
        reset = 1'b0;
        step(63);                               // 63
        chk("t6_not_yet_valid", 32'(sample_valid), 32'd0);
        step(1);                                // 64
        chk_out("t6_first", 1, 62, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
